// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
// The DISCARD state exists only when UART_FRAME_ADDR_FILTER_EN is defined.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
`ifdef UART_FRAME_ADDR_FILTER_EN
    , ST_DISCARD
`endif
  } frame_state_t;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] BCAST_ADDR    = 8'hFF;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter. Counts while enabled, saturates at LIMIT and
// flags expiry for as long as it sits there; a clear always wins.
module uart_frame_timeout #(
  parameter int LIMIT = 86800
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
  localparam logic [W-1:0] ONE_W   = W'(1);

  logic [W-1:0] count;

  // Idle counter: clear has priority, otherwise count up to the limit and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_W)) begin
      count <= count + ONE_W;
    end
  end

  assign expire = enable && (count == LIMIT_W);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser: SYNC, ADDR, LEN, payload, XOR checksum, with inter-byte timeout.
// Optional address filter enabled by defining UART_FRAME_ADDR_FILTER_EN.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 86800
`ifdef UART_FRAME_ADDR_FILTER_EN
  , parameter logic [7:0] MY_ADDR      = 8'h01
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       wr_en,
  output logic [$clog2(MAX_LEN)-1:0] wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       frame_done,
  output logic [7:0]                 frame_addr,
  output logic [7:0]                 frame_len,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

  frame_state_t state, state_n;

  logic [7:0]    addr_q, addr_n;
  logic [7:0]    len_q, len_n;
  logic [7:0]    chk, chk_n;
  logic [7:0]    idx, idx_n;
  logic          wr_en_n, done_n, err_n;
  logic [AW-1:0] wr_addr_n;
  logic [7:0]    wr_data_n, frame_addr_n, frame_len_n;
  logic [1:0]    err_code_n;
  logic          tmo_expire, tmo_clear;

  assign busy      = (state != ST_IDLE);
  assign tmo_clear = byte_valid || (state_n == ST_IDLE);

  uart_frame_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (busy),
    .expire (tmo_expire)
  );

  // State and all registered outputs update together from the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      chk        <= '0;
      idx        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_addr <= '0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      len_q      <= len_n;
      chk        <= chk_n;
      idx        <= idx_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= done_n;
      frame_addr <= frame_addr_n;
      frame_len  <= frame_len_n;
      frame_err  <= err_n;
      err_code   <= err_code_n;
    end
  end

  // Next-state and output decode; a byte arriving on the expiry cycle wins.
  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    len_n        = len_q;
    chk_n        = chk;
    idx_n        = idx;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    done_n       = 1'b0;
    frame_addr_n = frame_addr;
    frame_len_n  = frame_len;
    err_n        = 1'b0;
    err_code_n   = err_code;

    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == SYNC_BYTE) begin
            state_n = ST_ADDR;
            chk_n   = 8'h00;
          end
        end
        ST_ADDR: begin
          addr_n  = byte_data;
          chk_n   = byte_data;
          state_n = ST_LEN;
        end
        ST_LEN: begin
          len_n = byte_data;
          chk_n = chk ^ byte_data;
          idx_n = 8'h00;
          if (byte_data > MAX_LEN_B) begin
            err_n      = 1'b1;
            err_code_n = ERR_LEN;
            state_n    = ST_IDLE;
          end
`ifdef UART_FRAME_ADDR_FILTER_EN
          else if ((addr_q != MY_ADDR) && (addr_q != BCAST_ADDR)) begin
            state_n = ST_DISCARD;
          end
`endif
          else if (byte_data == 8'h00) begin
            state_n = ST_CHK;
          end else begin
            state_n = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_en_n   = 1'b1;
          wr_addr_n = idx[AW-1:0];
          wr_data_n = byte_data;
          chk_n     = chk ^ byte_data;
          idx_n     = idx + 8'd1;
          if (idx == (len_q - 8'd1)) begin
            state_n = ST_CHK;
          end
        end
        ST_CHK: begin
          if (byte_data == chk) begin
            done_n       = 1'b1;
            frame_addr_n = addr_q;
            frame_len_n  = len_q;
          end else begin
            err_n      = 1'b1;
            err_code_n = ERR_CHK;
          end
          state_n = ST_IDLE;
        end
`ifdef UART_FRAME_ADDR_FILTER_EN
        ST_DISCARD: begin
          if (idx == len_q) begin
            state_n = ST_IDLE;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
`endif
        default: state_n = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      err_n      = 1'b1;
      err_code_n = ERR_TMO;
      state_n    = ST_IDLE;
    end
  end

endmodule
